updown_counter_param: RTL
=========================

Name: updown_counter_param

Overview:
Parametrised successor to the fixed 4-bit up/down counter. Configurable width and terminal value, with wrap or saturate at the boundaries. Adds count enable, synchronous clear, parallel load, a terminal-count flag and registered overflow/underflow pulses. Used as a general-purpose event, address or timer counter in the sequential-circuit library; it is a drop-in superset when run with default parameters and with en=1, clr=0, load=0.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL. MAX_VAL ≤ 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- en  input  1  count enable.
- mode  input  1  0 = count up, 1 = count down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- ovf  output  1  overflow pulse, registered, one cycle.
- udf  output  1  underflow pulse, registered, one cycle.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- rst asserted:
  - count=0, ovf=0, udf=0 immediately, without waiting for a clock edge.
  - Deassertion takes effect at the next rising edge.
- Priority at each rising edge: clr > load > en > hold.
- clr=1:
  - count←0, ovf←0, udf←0.
- load=1 (clr=0):
  - count←din if din ≤ MAX_VAL, otherwise count←MAX_VAL (clamped).
  - ovf←0, udf←0.
- en=1, mode=0 (up):
  - count<MAX_VAL: count←count+1.
  - count==MAX_VAL: count←0 when SATURATE=0, hold MAX_VAL when SATURATE=1; ovf←1 in both cases.
- en=1, mode=1 (down):
  - count>0: count←count-1.
  - count==0: count←MAX_VAL when SATURATE=0, hold 0 when SATURATE=1; udf←1 in both cases.
- en=0, no clr/load:
  - count holds; ovf←0, udf←0.
- ovf and udf:
  - High for exactly the one cycle following the boundary edge.
  - Never both high in the same cycle.
- tc = en & ((~mode & count==MAX_VAL) | (mode & count==0)):
  - Asserted in the cycle before a wrap or saturate event.
  - Usable as a cascade enable for a following stage.
- Mode change:
  - Sampled each edge; takes effect on the same edge it is seen.
  - No dead cycle on up/down reversal.
- Arithmetic:
  - Internal next-state is computed WIDTH+1 bits wide; the boundary is detected by comparison with MAX_VAL, not by carry-out.
  - This keeps non-power-of-two MAX_VAL correct.
- Any X on en, mode, clr or load outside reset is a bench error.

Decomposition:
- Package updown_counter_pkg:
  - MODE_UP=1'b0, MODE_DOWN=1'b1.
  - Parameter legality check function (WIDTH range, MAX_VAL fits).
- Sub-module updown_counter_next (combinational):
  - Inputs: count, en, mode, clr, load, din.
  - Outputs: next_count, next_ovf, next_udf.
  - Takes MAX_VAL and SATURATE as parameters.
- Top holds the registers plus the tc decode.

Test Plan:
- Reset/up wrap:
  - Stimulus: WIDTH=4, defaults; rst pulse mid-cycle, then mode=0, en=1 for 17 cycles.
  - Response: count=0 immediately on rst; then 1..15, 0, 1; tc high at count=15; ovf high exactly one cycle after the 15→0 edge.
- Down wrap, non-power-of-two:
  - Stimulus: MAX_VAL=9; load din=2, then mode=1, en=1 for 4 cycles.
  - Response: count 2,1,0,9,8; udf pulses once after the 0→9 edge.
- Saturate:
  - Stimulus: SATURATE=1, WIDTH=4; load 14, up ×3; then load 1, down ×3.
  - Response: 14,15,15,15 with ovf high two cycles; 1,0,0,0 with udf high two cycles.
- Priority and clamping:
  - Stimulus: clr=1, load=1 and en=1 in the same cycle.
  - Response: count=0.
  - Stimulus: load=1 with en=1, din=12, MAX_VAL=9.
  - Response: count=9, ovf=0.
- Hold and reversal:
  - Stimulus: en=0 for 5 cycles; then count=5 with mode toggled every cycle.
  - Response: count constant while en=0; then 6,5,6,5; tc=0 throughout.
- Async reset mid-operation:
  - Stimulus: assert rst between clock edges while counting at count=7.
  - Response: count=0, ovf=0, udf=0 before the next edge; counting resumes from 0 one edge after rst deasserts.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared constants and elaboration-time parameter checks for the
// parametrised up/down counter.
package updown_counter_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Width must be 2..32 and the terminal value must be representable.
  function automatic bit params_legal(input int width, input longint unsigned max_val);
    bit ok;
    ok = 1'b0;
    if ((width >= 2) && (width <= 32)) begin
      ok = (max_val <= ((64'd1 << width) - 64'd1));
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Next-state logic: clear/load/count priority, clamping, wrap or saturate
// at the boundaries, and the boundary pulse requests.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] next_count,
  output logic             next_ovf,
  output logic             next_udf
);

  localparam logic [WIDTH:0] MAX_EXT = MAX_VAL[WIDTH:0];

  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] din_ext_s;
  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;

  // One extra bit so boundaries are found by comparing against MAX_VAL,
  // which keeps non-power-of-two terminal values correct.
  assign count_ext_s = {1'b0, count};
  assign din_ext_s   = {1'b0, din};
  assign inc_s       = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s       = count_ext_s - {{WIDTH{1'b0}}, 1'b1};

  // Priority: clear, then load, then count, otherwise hold.
  always_comb begin
    next_count = count;
    next_ovf   = 1'b0;
    next_udf   = 1'b0;
    if (clr) begin
      next_count = {WIDTH{1'b0}};
    end else if (load) begin
      if (din_ext_s > MAX_EXT) begin
        next_count = MAX_EXT[WIDTH-1:0];
      end else begin
        next_count = din;
      end
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (count_ext_s >= MAX_EXT) begin
            next_ovf   = 1'b1;
            next_count = SATURATE ? MAX_EXT[WIDTH-1:0] : {WIDTH{1'b0}};
          end else begin
            next_count = inc_s[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          if (count_ext_s == {(WIDTH+1){1'b0}}) begin
            next_udf   = 1'b1;
            next_count = SATURATE ? {WIDTH{1'b0}} : MAX_EXT[WIDTH-1:0];
          end else begin
            next_count = dec_s[WIDTH-1:0];
          end
        end
        default: begin
          next_count = count;
        end
      endcase
    end else begin
      next_count = count;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: state registers, registered boundary
// pulses and the combinational terminal-count decode.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH:0] MAX_EXT = MAX_VAL[WIDTH:0];

  if (!params_legal(WIDTH, MAX_VAL)) begin : g_param_check
    $error("updown_counter_param: illegal WIDTH/MAX_VAL combination");
  end

  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic             udf_r;
  logic [WIDTH-1:0] next_count_s;
  logic             next_ovf_s;
  logic             next_udf_s;

  updown_counter_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count_r),
    .en         (en),
    .mode       (mode),
    .clr        (clr),
    .load       (load),
    .din        (din),
    .next_count (next_count_s),
    .next_ovf   (next_ovf_s),
    .next_udf   (next_udf_s)
  );

  // Count and pulse registers; reset clears them without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      count_r <= next_count_s;
      ovf_r   <= next_ovf_s;
      udf_r   <= next_udf_s;
    end
  end

  // Flags the cycle before a wrap/saturate so a following stage can cascade.
  assign tc = en & ((~mode & ({1'b0, count_r} == MAX_EXT)) |
                    ( mode & (count_r == {WIDTH{1'b0}})));

  assign count = count_r;
  assign ovf   = ovf_r;
  assign udf   = udf_r;

endmodule
